// File: rtl/nlu_pkg.sv
// Shared types and AES S-box arithmetic for the nonlinear unit.
// Combinational helpers only; the S-box is computed, not tabulated.
package nlu_pkg;
   localparam int LANE_W    = 8;
   localparam int MAX_LANES = 16;
   localparam int MAX_W     = LANE_W * MAX_LANES;

   typedef struct packed {
      logic             valid;
      logic             dec;
      logic             acc;
      logic [MAX_W-1:0] data;
   } stage_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      logic [7:0] t;
      t = gf_inv(b);
      return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      logic [7:0] t;
      t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction
endpackage

// File: rtl/nlu_sbox_byte.sv
// Single-byte AES substitution, forward or inverse selected by dec; purely combinational.
module nlu_sbox_byte
   import nlu_pkg::*;
(
   input  logic [LANE_W-1:0] data,
   input  logic              dec,
   output logic [LANE_W-1:0] result
);
   always_comb result = dec ? sbox_inv(data) : sbox_fwd(data);
endmodule

// File: rtl/nlu_sbox_pipe.sv
// Elastic AES S-box pipeline over LANES bytes; NLU_SBOX_ACC_EN adds an XOR accumulator.
// Latency STAGES cycles, one transaction per cycle.
// Full valid/ready backpressure, ready ripples from out_ready; flush drops in-flight work.
module nlu_sbox_pipe
   import nlu_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
)(
   input  logic               ck,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_dec,
`ifdef NLU_SBOX_ACC_EN
   input  logic               in_acc,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [CNT_W-1:0]   out_cnt
);
   localparam int DW   = LANE_W * LANES;
   localparam int LAST = STAGES - 1;

   stage_t            st  [STAGES];
   stage_t            inc [STAGES];
   stage_t            in_rec;
   stage_t            lk_src;
   stage_t            lk_res;
   stage_t            pre;
   stage_t            fin;
   logic [DW-1:0]     sub;
   logic [STAGES-1:0] rdy;
   logic              acc_in;
   logic              unused_bits;

`ifdef NLU_SBOX_ACC_EN
   logic [DW-1:0] acc_reg;
   assign acc_in = in_acc;
`else
   assign acc_in = 1'b0;
`endif

   // A stage can load when empty or when everything downstream drains this cycle.
   always_comb begin
      logic r;
      rdy = '0;
      r   = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         r      = !st[k].valid | r;
         rdy[k] = r;
      end
   end

   assign in_ready = rdy[0] & !flush;

   always_comb begin
      in_rec              = '0;
      in_rec.valid        = in_valid & in_ready;
      in_rec.dec          = in_dec;
      in_rec.acc          = acc_in;
      in_rec.data[DW-1:0] = in_data;
   end

   if (STAGES == 1) begin : g_lk_in
      assign lk_src = in_rec;
   end else begin : g_lk_reg
      assign lk_src = st[0];
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      nlu_sbox_byte u_byte (
         .data   (lk_src.data[LANE_W*i +: LANE_W]),
         .dec    (lk_src.dec),
         .result (sub[LANE_W*i +: LANE_W])
      );
   end

   always_comb begin
      lk_res              = lk_src;
      lk_res.data         = '0;
      lk_res.data[DW-1:0] = sub;
   end

   if (STAGES == 3) begin : g_mid
      assign pre = st[1];
   end else begin : g_nomid
      assign pre = lk_res;
   end

   always_comb begin
      fin = pre;
`ifdef NLU_SBOX_ACC_EN
      if (pre.acc) fin.data[DW-1:0] = pre.data[DW-1:0] ^ acc_reg;
`endif
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         if (k == LAST)   inc[k] = fin;
         else if (k == 0) inc[k] = in_rec;
         else             inc[k] = lk_res;
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) st[k] <= '0;
         out_cnt <= '0;
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++) st[k].valid <= 1'b0;
         out_cnt <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               if (inc[k].valid) st[k] <= inc[k];
               else              st[k].valid <= 1'b0;
            end
         end
         if (out_valid && out_ready) out_cnt <= out_cnt + CNT_W'(1);
      end
   end

`ifdef NLU_SBOX_ACC_EN
   always_ff @(posedge ck or posedge rst) begin
      if (rst)                                 acc_reg <= '0;
      else if (flush)                          acc_reg <= '0;
      else if (rdy[LAST] && inc[LAST].valid)   acc_reg <= inc[LAST].data[DW-1:0];
   end
`endif

   assign out_valid = st[LAST].valid;
   assign out_data  = st[LAST].data[DW-1:0];

   // Record bits above DW and the result stage's mode flags ride along unread.
   assign unused_bits = ^{st[LAST], lk_src};
endmodule

// File: tb/tb_nlu_sbox_pipe.sv
// Directed bench for nlu_sbox_pipe with an in-order scoreboard built from GF(2^8) first principles.
module tb_nlu_sbox_pipe;
   logic        ck;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_dec;
   logic        in_acc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          started = 0;
   logic [7:0]  fwd_t [256];
   logic [7:0]  inv_t [256];
   logic [31:0] q [$];
   logic [3:0]  m_cnt = 4'd0;
   logic [31:0] m_acc = 32'd0;

   nlu_sbox_pipe #(.LANES(4), .STAGES(2), .CNT_W(4)) dut (
      .ck        (ck),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dec    (in_dec),
`ifdef NLU_SBOX_ACC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] aa;
      r  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return r;
   endfunction

   // Inverse by exhaustive search, then the bitwise affine map; inverse table by inverting the permutation.
   task automatic build_tables();
      logic [7:0] b;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
         fwd_t[x] = s;
      end
      for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
   endtask

   function automatic logic [31:0] model_sub(input logic [31:0] d, input logic dec);
      logic [31:0] r;
      for (int l = 0; l < 4; l++)
         r[8*l +: 8] = dec ? inv_t[d[8*l +: 8]] : fwd_t[d[8*l +: 8]];
      return r;
   endfunction

   always @(negedge ck) begin : mon
      logic [31:0] e;
      if (started && !rst) begin
         if (flush) check("in_ready_in_flush", 32'(in_ready), 32'd0);
         check("out_cnt", 32'(out_cnt), 32'(m_cnt));
         if (out_valid) begin
            check("out_valid_with_item", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) check("out_data", out_data, q[0]);
         end
         if (flush) begin
            q.delete();
            m_cnt = 4'd0;
            m_acc = 32'd0;
         end else begin
            if (out_valid && out_ready && q.size() > 0) begin
               void'(q.pop_front());
               m_cnt = m_cnt + 4'd1;
            end
            if (in_valid && in_ready) begin
               e = model_sub(in_data, in_dec);
`ifdef NLU_SBOX_ACC_EN
               if (in_acc) e = e ^ m_acc;
               m_acc = e;
`endif
               q.push_back(e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal;
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_dec = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
      build_tables();
      check("model_fwd_00", 32'(fwd_t[0]), 32'h63);
      check("model_fwd_93", 32'(fwd_t[8'h93]), 32'hdc);
      check("model_inv_26", 32'(inv_t[8'h26]), 32'h23);

      repeat (2) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_cnt", 32'(out_cnt), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      started = 1'b1;

      // forward then inverse back-to-back
      in_valid = 1'b1; in_data = 32'h93f5bae9; in_dec = 1'b0;
      tick();
      check("fwd_not_early", 32'(out_valid), 32'd0);
      in_data = 32'h26880ba3; in_dec = 1'b1;
      tick();
      check("fwd_valid", 32'(out_valid), 32'd1);
      check("fwd_data", out_data, 32'hdce6f41e);
      check("fwd_cnt0", 32'(out_cnt), 32'd0);
      in_valid = 1'b0;
      tick();
      check("inv_data", out_data, 32'h23979e71);
      check("fwd_cnt1", 32'(out_cnt), 32'd1);
      tick();
      check("inv_cnt2", 32'(out_cnt), 32'd2);
      check("idle_valid", 32'(out_valid), 32'd0);

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_dec = 1'b0; in_data = 32'h00000000;
      tick();
      check("bp_ready_1", 32'(in_ready), 32'd1);
      in_data = 32'h01010101;
      tick();
      check("bp_ready_full", 32'(in_ready), 32'd0);
      in_data = 32'h02020202;
      repeat (2) tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h63636363);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      check("bp_ready_comb", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_out1", out_data, 32'h7c7c7c7c);
      tick();
      check("bp_out2", out_data, 32'h77777777);
      tick();
      check("bp_drained", 32'(out_valid), 32'd0);
      check("bp_cnt", 32'(out_cnt), 32'd5);

      // asynchronous reset with two items in flight
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hdeadbeef; in_dec = 1'b1;
      tick();
      in_data = 32'hcafef00d; in_dec = 1'b0;
      tick();
      in_valid = 1'b0;
      check("mr_valid_before", 32'(out_valid), 32'd1);
      #1;
      rst = 1'b1;
      q.delete(); m_cnt = 4'd0; m_acc = 32'd0;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_data", out_data, 32'd0);
      check("mr_cnt", 32'(out_cnt), 32'd0);
      #1;
      rst = 1'b0; out_ready = 1'b1;
      tick();
      check("mr_no_partial", 32'(out_valid), 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd1);

      // flush with two items in flight, input offered during flush
      in_valid = 1'b1; in_data = 32'h11223344; in_dec = 1'b0;
      tick();
      in_data = 32'h55667788; in_dec = 1'b1;
      tick();
      in_data = 32'h99aabbcc; in_dec = 1'b0;
      tick();
      check("fl_cnt_before", 32'(out_cnt), 32'd1);
      flush = 1'b1; in_data = 32'ha5a5a5a5;
      #1;
      check("fl_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_cnt", 32'(out_cnt), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("fl_dropped", 32'(out_valid), 32'd0);
      end

`ifdef NLU_SBOX_ACC_EN
      in_valid = 1'b1; in_data = 32'h0; in_dec = 1'b0; in_acc = 1'b0;
      tick();
      in_acc = 1'b1;
      tick();
      in_valid = 1'b0; in_acc = 1'b0;
      check("acc_first", out_data, 32'h63636363);
      tick();
      check("acc_second", out_data, 32'h00000000);
      tick();
`endif

      // counter wrap with mixed enc/dec stream
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("wrap_start", 32'(out_cnt), 32'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         logic [7:0] b;
         b       = 8'(i);
         in_data = {b, b ^ 8'h5a, b + 8'h80, ~b};
         in_dec  = b[0];
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      check("wrap_cnt", 32'(out_cnt), 32'd1);
      check("wrap_idle", 32'(out_valid), 32'd0);
      check("wrap_queue_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
